// File: rtl/perf_monitor_pkg.sv
// Shared types and constants for the performance monitor.
// Holds the FSM state encoding and the read-select index of the cycle counter.
// No logic here.
package perf_monitor_pkg;

   // Monitor operating states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   // Read-select value (and counter array index) of the free-running cycle counter
   localparam int unsigned SEL_CYCLE = 0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a sticky overflow flag.
// Value and flag update one cycle after inc_i/en_i; no backpressure.
// Reset beats clear, clear beats counting; at all-ones it holds and flags.
module sat_counter #(
   parameter int unsigned W = 32
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         en_i,
   input  logic         inc_i,
   output logic [W-1:0] val_o,
   output logic         ovf_o
);

   logic [W-1:0] val_q;
   logic         ovf_q;
   logic         at_max;

   assign at_max = &val_q;

   // Count qualified increments; an increment attempted at all-ones sets the sticky flag instead
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         val_q <= '0;
         ovf_q <= 1'b0;
      end else if (clr_i) begin
         val_q <= '0;
         ovf_q <= 1'b0;
      end else if (en_i && inc_i) begin
         if (at_max) begin
            ovf_q <= 1'b1;
         end else begin
            val_q <= val_q + W'(1);
         end
      end
   end

   assign val_o = val_q;
   assign ovf_o = ovf_q;

endmodule

// File: rtl/perf_monitor.sv
// Cycle/event performance monitor with IDLE/RUN/HALT control and a registered read port.
// Read data has one cycle of latency; status outputs are registered alongside the state.
// No backpressure: every input is sampled each cycle, clear wins over run control.
module perf_monitor
   import perf_monitor_pkg::*;
#(
   parameter int unsigned     CNT_W     = 32,
   parameter int unsigned     NUM_EVT   = 4,
   parameter longint unsigned CYC_LIMIT = 30
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           start_i,
   input  logic                           clr_i,
   input  logic [NUM_EVT-1:0]             evt_i,
   input  logic [$clog2(NUM_EVT+1)-1:0]   rd_sel_i,
   output logic [CNT_W-1:0]               rd_data_o,
   output logic                           running_o,
   output logic                           halt_o,
   output logic [NUM_EVT:0]               ovf_o
);

   localparam int unsigned SEL_W = $clog2(NUM_EVT + 1);

   // A limit that does not fit in the counter can never be reached; the counter saturates instead
   localparam bit HALT_EN = (CYC_LIMIT != 64'd0) &&
                            ((CNT_W >= 64) || (CYC_LIMIT < (64'd1 << CNT_W)));

   // Halt is taken on the RUN cycle whose increment lands on the limit
   localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(CYC_LIMIT - 64'd1);

   state_t           state_q;
   logic             running_q;
   logic             halt_q;
   logic [CNT_W-1:0] rd_q;
   logic [CNT_W-1:0] rd_d;

   logic             run_en;
   logic             limit_hit;
   logic [CNT_W-1:0] cnt_val [NUM_EVT+1];
   logic [NUM_EVT:0] ovf;

   assign run_en    = (state_q == RUN);
   assign limit_hit = HALT_EN && run_en && (cnt_val[SEL_CYCLE] == LIMIT_M1);

   // Cycle counter: increments on every RUN cycle
   sat_counter #(.W(CNT_W)) u_cyc (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (clr_i),
      .en_i  (run_en),
      .inc_i (1'b1),
      .val_o (cnt_val[SEL_CYCLE]),
      .ovf_o (ovf[SEL_CYCLE])
   );

   // Event counters: slot k+1 counts strobes on evt_i[k] during RUN
   for (genvar k = 0; k < NUM_EVT; k++) begin : g_evt
      sat_counter #(.W(CNT_W)) u_evt (
         .clk_i (clk_i),
         .rst_i (rst_i),
         .clr_i (clr_i),
         .en_i  (run_en),
         .inc_i (evt_i[k]),
         .val_o (cnt_val[k+1]),
         .ovf_o (ovf[k+1])
      );
   end

   // Control FSM with status outputs registered together with the state
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q   <= IDLE;
         running_q <= 1'b0;
         halt_q    <= 1'b0;
      end else if (clr_i) begin
         state_q   <= IDLE;
         running_q <= 1'b0;
         halt_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  state_q   <= RUN;
                  running_q <= 1'b1;
               end
            end
            RUN: begin
               if (limit_hit) begin
                  state_q   <= HALT;
                  running_q <= 1'b0;
                  halt_q    <= 1'b1;
               end else if (!start_i) begin
                  state_q   <= IDLE;
                  running_q <= 1'b0;
               end
            end
            HALT: begin
               // Frozen until clear or reset
            end
            default: begin
               state_q   <= IDLE;
               running_q <= 1'b0;
               halt_q    <= 1'b0;
            end
         endcase
      end
   end

   // Read mux; selects beyond the last event counter read as zero
   always_comb begin
      rd_d = '0;
      for (int k = 0; k <= int'(NUM_EVT); k++) begin
         if (rd_sel_i == SEL_W'(k)) begin
            rd_d = cnt_val[k];
         end
      end
   end

   // Register the selected counter value
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         rd_q <= '0;
      end else begin
         rd_q <= rd_d;
      end
   end

   assign rd_data_o = rd_q;
   assign running_o = running_q;
   assign halt_o    = halt_q;
   assign ovf_o     = ovf;

endmodule

// File: tb/tb_perf_monitor.sv
// Directed bench for perf_monitor: a vector table for run/pause/read-select behaviour,
// plus sequences for halt, clear, reset-in-halt and saturation (4-bit counters).
module tb_perf_monitor;

   logic        clk;

   // Default-parameter instance (CNT_W=32, NUM_EVT=4, CYC_LIMIT=30)
   logic        rst, clr, start;
   logic [3:0]  evt;
   logic [2:0]  sel;
   logic [31:0] rd;
   logic        running, halt;
   logic [4:0]  ovf;

   // Narrow, never-halting instance for saturation
   logic        rst4, clr4, start4;
   logic [3:0]  evt4;
   logic [2:0]  sel4;
   logic [3:0]  rd4;
   logic        running4, halt4;
   logic [4:0]  ovf4;

   int n_chk  = 0;
   int n_fail = 0;

   perf_monitor #(.CNT_W(32), .NUM_EVT(4), .CYC_LIMIT(30)) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .start_i   (start),
      .clr_i     (clr),
      .evt_i     (evt),
      .rd_sel_i  (sel),
      .rd_data_o (rd),
      .running_o (running),
      .halt_o    (halt),
      .ovf_o     (ovf)
   );

   perf_monitor #(.CNT_W(4), .NUM_EVT(4), .CYC_LIMIT(0)) dut4 (
      .clk_i     (clk),
      .rst_i     (rst4),
      .start_i   (start4),
      .clr_i     (clr4),
      .evt_i     (evt4),
      .rd_sel_i  (sel4),
      .rd_data_o (rd4),
      .running_o (running4),
      .halt_o    (halt4),
      .ovf_o     (ovf4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        start;
      logic [3:0]  evt;
      logic [2:0]  sel;
      logic [31:0] rd;
      logic        run;
   } vec_t;

   localparam int NV = 22;
   vec_t tbl [NV];

   function automatic vec_t mk(input logic r, input logic s, input logic [3:0] e,
                               input logic [2:0] sl, input logic [31:0] exp_rd,
                               input logic exp_run);
      vec_t v;
      v.rst = r; v.start = s; v.evt = e; v.sel = sl; v.rd = exp_rd; v.run = exp_run;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   initial begin
      rst = 1'b0; clr = 1'b0; start = 1'b0; evt = 4'h0; sel = 3'd0;
      rst4 = 1'b0; clr4 = 1'b0; start4 = 1'b0; evt4 = 4'h0; sel4 = 3'd0;

      // Run 5, pause 4 with all events high, resume 3, then read every select
      tbl[0]  = mk(1'b0, 1'b0, 4'h0, 3'd0, 32'd0, 1'b0); // reset
      tbl[1]  = mk(1'b1, 1'b1, 4'h0, 3'd0, 32'd0, 1'b1); // IDLE->RUN, no count
      tbl[2]  = mk(1'b1, 1'b1, 4'h1, 3'd0, 32'd0, 1'b1); // cyc=1
      tbl[3]  = mk(1'b1, 1'b1, 4'h3, 3'd0, 32'd1, 1'b1); // cyc=2
      tbl[4]  = mk(1'b1, 1'b1, 4'h7, 3'd0, 32'd2, 1'b1); // cyc=3
      tbl[5]  = mk(1'b1, 1'b1, 4'h1, 3'd0, 32'd3, 1'b1); // cyc=4
      tbl[6]  = mk(1'b1, 1'b0, 4'hF, 3'd0, 32'd4, 1'b0); // last RUN cycle counts, cyc=5
      tbl[7]  = mk(1'b1, 1'b0, 4'hF, 3'd0, 32'd5, 1'b0); // paused: events ignored
      tbl[8]  = mk(1'b1, 1'b0, 4'hF, 3'd0, 32'd5, 1'b0);
      tbl[9]  = mk(1'b1, 1'b0, 4'hF, 3'd0, 32'd5, 1'b0);
      tbl[10] = mk(1'b1, 1'b1, 4'h8, 3'd0, 32'd5, 1'b1); // re-enter, event ignored
      tbl[11] = mk(1'b1, 1'b1, 4'h0, 3'd0, 32'd5, 1'b1); // cyc=6
      tbl[12] = mk(1'b1, 1'b1, 4'h0, 3'd0, 32'd6, 1'b1); // cyc=7
      tbl[13] = mk(1'b1, 1'b0, 4'h0, 3'd0, 32'd7, 1'b0); // cyc=8, back to IDLE
      tbl[14] = mk(1'b1, 1'b0, 4'h0, 3'd0, 32'd8, 1'b0);
      tbl[15] = mk(1'b1, 1'b0, 4'h0, 3'd1, 32'd5, 1'b0); // evt0
      tbl[16] = mk(1'b1, 1'b0, 4'h0, 3'd2, 32'd3, 1'b0); // evt1
      tbl[17] = mk(1'b1, 1'b0, 4'h0, 3'd3, 32'd2, 1'b0); // evt2
      tbl[18] = mk(1'b1, 1'b0, 4'h0, 3'd4, 32'd1, 1'b0); // evt3
      tbl[19] = mk(1'b1, 1'b0, 4'h0, 3'd5, 32'd0, 1'b0); // out of range
      tbl[20] = mk(1'b1, 1'b0, 4'h0, 3'd7, 32'd0, 1'b0); // out of range
      tbl[21] = mk(1'b1, 1'b0, 4'h0, 3'd0, 32'd8, 1'b0); // cycle counter again

      for (int i = 0; i < NV; i++) begin
         rst = tbl[i].rst; start = tbl[i].start; evt = tbl[i].evt; sel = tbl[i].sel;
         tick();
         chk($sformatf("vec%0d rd", i),   64'(rd),      64'(tbl[i].rd));
         chk($sformatf("vec%0d run", i),  64'(running), 64'(tbl[i].run));
         chk($sformatf("vec%0d halt", i), 64'(halt),    64'd0);
         chk($sformatf("vec%0d ovf", i),  64'(ovf),     64'd0);
      end

      // Halt after 30 RUN cycles; evt0 in RUN cycles 2, 5, 9
      rst = 1'b0; start = 1'b0; evt = 4'h0; sel = 3'd0;
      tick();
      rst = 1'b1; start = 1'b1;
      tick();
      for (int n = 1; n <= 30; n++) begin
         evt = (n == 2 || n == 5 || n == 9) ? 4'h1 : 4'h0;
         tick();
         if (n == 29) begin
            chk("halt_before_limit", 64'(halt), 64'd0);
            chk("running_before_limit", 64'(running), 64'd1);
         end
      end
      chk("halt_at_limit", 64'(halt), 64'd1);
      chk("running_at_limit", 64'(running), 64'd0);
      evt = 4'hF;
      for (int n = 0; n < 5; n++) tick();
      evt = 4'h0; sel = 3'd0;
      tick();
      chk("halt_cyc_cnt", 64'(rd), 64'd30);
      sel = 3'd1;
      tick();
      chk("halt_evt0_cnt", 64'(rd), 64'd3);
      sel = 3'd2;
      tick();
      chk("halt_evt1_cnt", 64'(rd), 64'd0);
      chk("halt_still_set", 64'(halt), 64'd1);
      chk("halt_ovf", 64'(ovf), 64'd0);

      // One reset edge in HALT, then restart from zero
      rst = 1'b0; sel = 3'd0;
      tick();
      chk("rst_halt_halt", 64'(halt), 64'd0);
      chk("rst_halt_rd", 64'(rd), 64'd0);
      chk("rst_halt_running", 64'(running), 64'd0);
      rst = 1'b1; start = 1'b1;
      tick();
      chk("restart_enter_rd", 64'(rd), 64'd0);
      tick(); tick(); tick();
      start = 1'b0;
      tick();
      chk("restart_rd3", 64'(rd), 64'd3);
      tick();
      chk("restart_rd4", 64'(rd), 64'd4);

      // Clear with start and all events high while running at count 12
      rst = 1'b0;
      tick();
      rst = 1'b1; start = 1'b1; evt = 4'h5;
      tick();
      for (int n = 0; n < 12; n++) tick();
      clr = 1'b1; evt = 4'hF; sel = 3'd0;
      tick();
      chk("clr_prev_cyc", 64'(rd), 64'd12);
      chk("clr_running", 64'(running), 64'd0);
      chk("clr_halt", 64'(halt), 64'd0);
      chk("clr_ovf", 64'(ovf), 64'd0);
      clr = 1'b0; start = 1'b0; evt = 4'h0;
      for (int k = 0; k <= 4; k++) begin
         sel = 3'(k);
         tick();
         chk($sformatf("clr_cnt%0d", k), 64'(rd), 64'd0);
      end

      // 4-bit counters, no limit: evt1 held for 20 RUN cycles
      rst4 = 1'b0;
      tick();
      rst4 = 1'b1; start4 = 1'b1;
      tick();
      for (int n = 1; n <= 20; n++) begin
         evt4 = 4'h2;
         start4 = (n < 20);
         tick();
         if (n == 10) chk("sat_ovf_mid", 64'(ovf4), 64'd0);
      end
      evt4 = 4'h0; start4 = 1'b0; sel4 = 3'd0;
      tick();
      chk("sat_cyc_cnt", 64'(rd4), 64'd15);
      chk("sat_halt", 64'(halt4), 64'd0);
      sel4 = 3'd2;
      tick();
      chk("sat_evt1_cnt", 64'(rd4), 64'd15);
      sel4 = 3'd1;
      tick();
      chk("sat_evt0_cnt", 64'(rd4), 64'd0);
      chk("sat_ovf_vec", 64'(ovf4), 64'h05);
      chk("sat_ovf_evt1", 64'(ovf4[2]), 64'd1);
      chk("sat_ovf_evt0", 64'(ovf4[1]), 64'd0);
      clr4 = 1'b1;
      tick();
      clr4 = 1'b0;
      chk("sat_ovf_cleared", 64'(ovf4), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/perf_monitor.md
PERF_MONITOR -- requirements
Module: perf_monitor

Interface
REQ-001 Parameter CNT_W, default 32: width of every counter, legal 4..64.
REQ-002 Parameter NUM_EVT, default 4: number of event channels, legal 1..16.
REQ-003 Parameter CYC_LIMIT, default 30: number of RUN cycles after which the monitor halts; 0 = never halt.
REQ-004 clk_i  input  1  sole clock, all state updates on rising edge.
REQ-005 rst_i  input  1  reset; one clock, synchronous and active-low.
REQ-006 start_i  input  1  level run-enable; 1 = count, 0 = pause.
REQ-007 clr_i  input  1  synchronous clear of counters, flags and FSM.
REQ-008 evt_i  input  NUM_EVT  per-cycle event strobes (stall, flush, retire, ...).
REQ-009 rd_sel_i  input  $clog2(NUM_EVT+1)  read select: 0 = cycle counter, k = event counter k-1.
REQ-010 rd_data_o  output  CNT_W  registered value of the selected counter.
REQ-011 running_o  output  1  state is RUN.
REQ-012 halt_o  output  1  state is HALT (cycle limit reached).
REQ-013 ovf_o  output  NUM_EVT+1  sticky saturation flags; bit 0 = cycle counter, bit k = event k-1.

Function
REQ-014 FSM states IDLE, RUN, HALT; next state is evaluated as follows, with clr_i having highest priority.
REQ-015 clr_i=1 in any state: next state IDLE, all counters 0, ovf_o 0; overrides start_i and evt_i in that cycle.
REQ-016 IDLE -> RUN when start_i=1; no counting in the IDLE cycle itself.
REQ-017 RUN: cycle counter +1 each cycle; event counter k +1 in each cycle where evt_i[k]=1.
REQ-018 RUN -> IDLE when start_i=0; counters hold; re-entering RUN resumes from held values.
REQ-019 RUN -> HALT in the cycle where the cycle counter increments to CYC_LIMIT (CYC_LIMIT != 0); events in that cycle are counted.
REQ-020 HALT: counters frozen, start_i and evt_i ignored; exit only via clr_i or rst_i.
REQ-021 Events in IDLE or HALT are ignored.
REQ-022 Counter at all-ones stays at all-ones (saturates, no wrap) and sets its ovf_o bit, which stays set until clr_i or reset.
REQ-023 rd_data_o = selected counter value as of the previous edge (1-cycle latency); rd_sel_i > NUM_EVT returns 0.
REQ-024 CYC_LIMIT greater than 2^CNT_W-1 is treated as never halting; the cycle counter saturates instead.

Reset
REQ-025 rst_i=0 at a rising edge: state IDLE, all counters 0, ovf_o 0, rd_data_o 0, running_o 0, halt_o 0.
REQ-026 Reset mid-RUN or in HALT discards all counts; no partial update occurs in the reset cycle.
REQ-027 Reset has priority over clr_i and start_i.

Structure
REQ-028 Shared package perf_monitor_pkg holds the state enum (IDLE/RUN/HALT) and the constant SEL_CYCLE = 0.
REQ-029 One sub-module sat_counter (CNT_W wide, inc/clr/en inputs, value and ovf outputs) is instantiated NUM_EVT+1 times.
REQ-030 Estimated size 150-300 lines of RTL in total; no multicycle paths; all outputs are registered or derived directly from state.

Verification
REQ-031 Reset; start_i=1; evt_i[0] pulsed in RUN cycles 2, 5, 9 -> after 30 RUN cycles halt_o=1; cycle count 30; evt0 count 3; further events do not change any counter.
REQ-032 CNT_W=4, CYC_LIMIT=0; evt_i[1] held 20 RUN cycles -> evt1 count 15, ovf_o[2]=1, ovf_o[1]=0; cycle count 15 with ovf_o[0]=1.
REQ-033 Run 5 cycles, start_i=0 for 4 cycles with evt_i all 1, then start_i=1 for 3 cycles -> cycle count 8, running_o low exactly during the pause.
REQ-034 clr_i=1 together with start_i=1 and evt_i all 1 while in RUN at count 12 -> next cycle all counters 0, state IDLE, ovf_o 0.
REQ-035 rst_i=0 for one edge in HALT -> halt_o 0, rd_data_o 0 after the edge; start_i=1 then restarts counting from 0.
REQ-036 Sweep rd_sel_i 0..NUM_EVT+1 -> each value appears one cycle after select; select NUM_EVT+1 returns 0.
